shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 150 +++++++++++++++
 tb/tb_shift_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Pipelined log2 barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake.
// PIPE=0 registers only the result; PIPE=1 registers after every shift stage.
module shift_unit #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned PIPE  = 0,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic             en;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             co_q;
  logic             zero_q;

  // Stage k inputs (index 0 is the request itself) and stage k outputs.
  logic [WIDTH-1:0] stg_data [SHW];
  logic [1:0]       stg_op   [SHW];
  logic [SHW-1:0]   stg_sh   [SHW];
  logic             stg_co   [SHW];
  logic             stg_vld  [SHW];
  logic [WIDTH-1:0] nxt_data [SHW];
  logic             nxt_co   [SHW];

  // One global advance enable: the whole pipe moves or the whole pipe holds.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign stg_data[0] = A;
  assign stg_op[0]   = op;
  assign stg_sh[0]   = shamt;
  assign stg_co[0]   = 1'b0;
  assign stg_vld[0]  = in_valid;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned DIST = 1 << k;

    logic [WIDTH-1:0] data_d;
    logic             co_d;

    // Carry tracks the last bit shifted out; for ROR it ends up equal to res MSB.
    always_comb begin
      data_d = stg_data[k];
      co_d   = stg_co[k];
      if (stg_sh[k][k]) begin
        case (stg_op[k])
          OP_SLL: begin
            data_d = stg_data[k] << DIST;
            co_d   = stg_data[k][WIDTH-DIST];
          end
          OP_SRL: begin
            data_d = stg_data[k] >> DIST;
            co_d   = stg_data[k][DIST-1];
          end
          OP_SRA: begin
            data_d = $signed(stg_data[k]) >>> DIST;
            co_d   = stg_data[k][DIST-1];
          end
          OP_ROR: begin
            data_d = (stg_data[k] >> DIST) | (stg_data[k] << (WIDTH - DIST));
            co_d   = stg_data[k][DIST-1];
          end
          default: begin
            data_d = stg_data[k];
            co_d   = stg_co[k];
          end
        endcase
      end
    end

    assign nxt_data[k] = data_d;
    assign nxt_co[k]   = co_d;

    if (k < SHW - 1) begin : g_link
      if (PIPE != 0) begin : g_reg
        logic [WIDTH-1:0] data_q;
        logic [1:0]       op_q;
        logic [SHW-1:0]   sh_q;
        logic             co_q;
        logic             vld_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            data_q <= '0;
            op_q   <= '0;
            sh_q   <= '0;
            co_q   <= 1'b0;
            vld_q  <= 1'b0;
          end else if (en) begin
            data_q <= data_d;
            op_q   <= stg_op[k];
            sh_q   <= stg_sh[k];
            co_q   <= co_d;
            vld_q  <= stg_vld[k];
          end
        end

        assign stg_data[k+1] = data_q;
        assign stg_op[k+1]   = op_q;
        assign stg_sh[k+1]   = sh_q;
        assign stg_co[k+1]   = co_q;
        assign stg_vld[k+1]  = vld_q;
      end else begin : g_comb
        assign stg_data[k+1] = data_d;
        assign stg_op[k+1]   = stg_op[k];
        assign stg_sh[k+1]   = stg_sh[k];
        assign stg_co[k+1]   = co_d;
        assign stg_vld[k+1]  = stg_vld[k];
      end
    end
  end

  // Output register; zero is derived from the same value loaded into res.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      co_q        <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= stg_vld[SHW-1];
      res_q       <= nxt_data[SHW-1];
      co_q        <= nxt_co[SHW-1];
      zero_q      <= (nxt_data[SHW-1] == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign co        = co_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: one PIPE=0 and one PIPE=1 instance, WIDTH=32.
module tb_shift_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0, iv0, ir0, ov0, or0, co0, z0;
  logic [W-1:0]  a0, r0;
  logic [SW-1:0] s0;
  logic [1:0]    op0;

  logic          rst1, iv1, ir1, ov1, or1, co1, z1;
  logic [W-1:0]  a1, r1;
  logic [SW-1:0] s1;
  logic [1:0]    op1;

  shift_unit #(.WIDTH(W), .PIPE(0)) u0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .A(a0), .shamt(s0), .op(op0),
    .out_valid(ov0), .out_ready(or0), .res(r0), .co(co0), .zero(z0)
  );

  shift_unit #(.WIDTH(W), .PIPE(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .A(a1), .shamt(s1), .op(op1),
    .out_valid(ov1), .out_ready(or1), .res(r1), .co(co1), .zero(z1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-computed vectors: op 0=SLL 1=SRL 2=SRA 3=ROR.
  logic [31:0] va [16] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                           32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000001, 32'h80000001,
                           32'h12345678, 32'h80000001, 32'h00000001, 32'h00000003,
                           32'h80000000, 32'h00000001, 32'h80000000, 32'h87654321};
  logic [4:0]  vs [16] = '{5'd1, 5'd3, 5'd4, 5'd4, 5'd4, 5'd4, 5'd1, 5'd1,
                           5'd0, 5'd0, 5'd1, 5'd31, 5'd31, 5'd31, 5'd31, 5'd0};
  logic [1:0]  vo [16] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2,
                           2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2};
  logic [31:0] vr [16] = '{32'h78787878, 32'h1E1E1E1E, 32'h0F0F0F0F, 32'h0F0F0F00,
                           32'hFF0F0F0F, 32'h0F0F0F0F, 32'h00000000, 32'hC0000000,
                           32'h12345678, 32'h80000001, 32'h80000000, 32'h80000000,
                           32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h87654321};
  logic        vc [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  int sent, got, seen, lat;

  initial begin
    rst0 = 1'b1; iv0 = 1'b0; or0 = 1'b1; a0 = '0; s0 = '0; op0 = '0;
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b1; a1 = '0; s1 = '0; op1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("u0_rst_valid", 64'(ov0), 64'd0);
    chk("u0_rst_res",   64'(r0),  64'd0);
    chk("u0_rst_zero",  64'(z0),  64'd0);
    chk("u0_rst_co",    64'(co0), 64'd0);
    chk("u1_rst_valid", 64'(ov1), 64'd0);
    chk("u1_rst_res",   64'(r1),  64'd0);
    chk("u1_rst_zero",  64'(z1),  64'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("u0_ready_after_rst", 64'(ir0), 64'd1);
    chk("u1_ready_after_rst", 64'(ir1), 64'd1);

    // PIPE=0 back-to-back stream, one result per cycle.
    for (int i = 0; i < 16; i++) begin
      iv0 = 1'b1; a0 = va[i]; s0 = vs[i]; op0 = vo[i];
      @(posedge clk); @(negedge clk);
      chk($sformatf("u0_v%0d_valid", i), 64'(ov0), 64'd1);
      chk($sformatf("u0_v%0d_res", i),   64'(r0),  64'(vr[i]));
      chk($sformatf("u0_v%0d_co", i),    64'(co0), 64'(vc[i]));
      chk($sformatf("u0_v%0d_zero", i),  64'(z0),  64'(vr[i] == 32'd0));
    end
    iv0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("u0_bubble_valid", 64'(ov0), 64'd0);

    // PIPE=0 stall: output held, new request not taken until out_ready.
    or0 = 1'b0; iv0 = 1'b1; a0 = va[3]; s0 = vs[3]; op0 = vo[3];
    @(posedge clk); @(negedge clk);
    chk("u0_stall_valid", 64'(ov0), 64'd1);
    chk("u0_stall_ready", 64'(ir0), 64'd0);
    chk("u0_stall_res0",  64'(r0),  64'(vr[3]));
    a0 = va[4]; s0 = vs[4]; op0 = vo[4];
    @(posedge clk); @(negedge clk);
    chk("u0_stall_res1",  64'(r0),  64'(vr[3]));
    chk("u0_stall_co1",   64'(co0), 64'(vc[3]));
    or0 = 1'b1;
    #1;
    chk("u0_unstall_ready", 64'(ir0), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("u0_after_stall_res", 64'(r0),  64'(vr[4]));
    chk("u0_after_stall_co",  64'(co0), 64'(vc[4]));
    iv0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("u0_drained_valid", 64'(ov0), 64'd0);

    // PIPE=1: 8 mixed-op requests, consumer stalls from cycle 3 to cycle 11.
    sent = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      or1 = (c < 3 || c >= 12);
      iv1 = (sent < 8);
      if (sent < 8) begin
        a1 = va[sent]; s1 = vs[sent]; op1 = vo[sent];
      end
      #1;
      if (c == 10) begin
        chk("u1_stall_ready", 64'(ir1), 64'd0);
        chk("u1_stall_valid", 64'(ov1), 64'd1);
        chk("u1_stall_res",   64'(r1),  64'(vr[0]));
      end
      if (iv1 && ir1) sent++;
      if (ov1 && or1) begin
        chk($sformatf("u1_r%0d_res", got), 64'(r1),  64'(vr[got]));
        chk($sformatf("u1_r%0d_co", got),  64'(co1), 64'(vc[got]));
        got++;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("u1_sent_count", 64'(sent), 64'd8);
    chk("u1_got_count",  64'(got),  64'd8);
    or1 = 1'b1; iv1 = 1'b0;
    #1;
    chk("u1_no_extra", 64'(ov1), 64'd0);

    // PIPE=1 latency with an empty pipe.
    iv1 = 1'b1; a1 = va[10]; s1 = vs[10]; op1 = vo[10];
    @(posedge clk); @(negedge clk);
    iv1 = 1'b0;
    lat = 1;
    while (!ov1 && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("u1_latency", 64'(lat), 64'd5);
    chk("u1_lat_res", 64'(r1),  64'(vr[10]));
    @(posedge clk); @(negedge clk);

    // PIPE=1 reset with 3 requests in flight plus one presented during reset.
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1; a1 = va[11+i]; s1 = vs[11+i]; op1 = vo[11+i];
      @(posedge clk); @(negedge clk);
    end
    rst1 = 1'b1; a1 = va[14]; s1 = vs[14]; op1 = vo[14];
    @(posedge clk); @(negedge clk);
    rst1 = 1'b0; iv1 = 1'b0;
    chk("u1_midrst_valid", 64'(ov1), 64'd0);
    chk("u1_midrst_res",   64'(r1),  64'd0);
    chk("u1_midrst_zero",  64'(z1),  64'd0);
    chk("u1_midrst_co",    64'(co1), 64'd0);
    #1;
    chk("u1_midrst_ready", 64'(ir1), 64'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (ov1) seen++;
    end
    chk("u1_flushed_results", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
